instruction_cache_dm: RTL
=========================

Name: instruction_cache_dm

Overview:
- Parametrised direct-mapped instruction cache between the fetch stage and instruction memory.
- Serves fetches from a PC with one-cycle hit latency.
- On a miss, refills a full line from memory over a valid/ready-style read handshake.
- Supports fetch stall and whole-cache flush (e.g. after FENCE.I).

Parameters:
ADDRESS_WIDTH, 32, width of PC and memory address.
DATA_WIDTH, 32, instruction/word width; fixed 4-byte word addressing.
LINE_COUNT, 64, number of cache lines; power of two, at least 2.
WORDS_PER_LINE, 4, words per line; power of two, at least 2.
HIGH, 1'b1, logic-high constant.
LOW, 1'b0, logic-low constant.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous active-high reset.
PC  input  ADDRESS_WIDTH  fetch address; bits [1:0] ignored.
PC_VALID  input  1  fetch request valid this cycle.
INSTRUCTION_CACHE_STALL  input  1  pipeline stall; freezes fetch-side outputs.
FLUSH  input  1  one-cycle pulse that invalidates all lines.
INSTRUCTION  output  DATA_WIDTH  fetched instruction (registered).
INSTRUCTION_CACHE_READY  output  1  INSTRUCTION is valid for the PC presented on the previous accepted cycle.
MEM_READ_REQUEST  output  1  word read request to memory.
MEM_ADDRESS  output  ADDRESS_WIDTH  word-aligned read address.
MEM_READ_DATA  input  DATA_WIDTH  returned word.
MEM_READ_VALID  input  1  MEM_READ_DATA valid; completes the outstanding request.

Behaviour:
- Address split, LSB first:
  - 2 byte bits.
  - WO = log2(WORDS_PER_LINE) word-offset bits.
  - IX = log2(LINE_COUNT) index bits.
  - Remaining bits are the tag.
- Storage: data array LINE_COUNT x WORDS_PER_LINE words; tag array; valid bit per line.
- Reset (RST=1 at edge):
  - All valid bits cleared; FSM to IDLE; word counter 0.
  - INSTRUCTION=0, INSTRUCTION_CACHE_READY=0, MEM_READ_REQUEST=0, MEM_ADDRESS=0.
  - Reset mid-refill aborts the refill immediately. A later MEM_READ_VALID is ignored.
- FSM states: IDLE, REFILL, UPDATE.
- IDLE, with PC_VALID=1 and STALL=0 at the edge:
  - Hit (valid and tag match): next cycle INSTRUCTION = word, READY=1.
  - Miss: next cycle READY=0, PC latched, go to REFILL.
  - With PC_VALID=0 and STALL=0: READY=0 next cycle.
- REFILL:
  - MEM_READ_REQUEST=1 with MEM_ADDRESS = {tag, index, counter, 2'b00}. The counter starts at 0, so the first request is line-aligned.
  - Request and address are held stable until MEM_READ_VALID=1.
  - On each valid beat: write the word at the counter position, increment the counter.
  - MEM_READ_VALID with no request outstanding is ignored.
  - After the beat for word WORDS_PER_LINE-1: MEM_READ_REQUEST drops the same edge, go to UPDATE.
  - Exactly WORDS_PER_LINE requests per miss, in ascending order.
- UPDATE (1 cycle):
  - Write tag; set valid unless a flush was recorded during this refill.
  - Drive INSTRUCTION = the latched-PC word and READY=1 on the next edge (STALL permitting); return to IDLE.
- STALL=1 at an edge:
  - INSTRUCTION and READY hold their values; PC is not sampled.
  - A refill in progress continues. If STALL is high at the UPDATE edge, line-array writes still occur, but output delivery waits in UPDATE until STALL=0.
- FLUSH:
  - Clears all valid bits at the edge, in one cycle.
  - During REFILL/UPDATE, a flush-pending flag forces the refilled line invalid. The current fetch is still delivered.
  - FLUSH together with a PC in IDLE: lookup treats the cache as all-invalid (miss).
- Index wrap: addresses differing only in tag map to the same line; a refill overwrites it.
- Miss penalty with zero-wait memory: WORDS_PER_LINE + 2 cycles from PC sample to READY.

Test Plan:
- Reset: assert RST 2 cycles with PC_VALID=1 -> READY=0, MEM_READ_REQUEST=0, INSTRUCTION=0. First fetch after reset misses.
- Cold miss at PC=0x104 (defaults), memory 2-cycle latency returning addr^0xA5A5A5A5 -> requests 0x100, 0x104, 0x108, 0x10C in order, each held until valid. READY=1 with INSTRUCTION=0xA5A5A4A1 the cycle after UPDATE.
- Hit sequence after refill: PC 0x100, 0x108, 0x10C on consecutive cycles -> READY=1 each next cycle with correct words. No MEM_READ_REQUEST.
- Conflict: fetch 0x500 (same index as 0x100) -> refill 0x500..0x50C. A subsequent 0x100 misses again.
- Stall: hit 0x104, then STALL=1 for 3 cycles while PC changes to 0x108 -> INSTRUCTION/READY frozen. The 0x108 result appears 1 cycle after STALL drops.
- Flush/reset mid-refill:
  - FLUSH during the second refill beat -> fetch delivered, but a re-fetch of the same line misses.
  - RST during REFILL -> request drops the next cycle; a stray MEM_READ_VALID has no effect.

Source files
------------

// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache sitting between fetch and instruction memory.
// A hit returns the instruction one cycle after the PC is sampled. A miss refills
// the whole line one word at a time over a request/valid read channel, then
// delivers the requested word from the freshly written line.
module instruction_cache_dm #(
    parameter int   ADDRESS_WIDTH  = 32,
    parameter int   DATA_WIDTH     = 32,
    parameter int   LINE_COUNT     = 64,
    parameter int   WORDS_PER_LINE = 4,
    parameter logic HIGH           = 1'b1,
    parameter logic LOW            = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    input  logic                     PC_VALID,
    input  logic                     INSTRUCTION_CACHE_STALL,
    input  logic                     FLUSH,
    output logic [DATA_WIDTH-1:0]    INSTRUCTION,
    output logic                     INSTRUCTION_CACHE_READY,
    output logic                     MEM_READ_REQUEST,
    output logic [ADDRESS_WIDTH-1:0] MEM_ADDRESS,
    input  logic [DATA_WIDTH-1:0]    MEM_READ_DATA,
    input  logic                     MEM_READ_VALID
);

    localparam int WO = $clog2(WORDS_PER_LINE);
    localparam int IX = $clog2(LINE_COUNT);
    localparam int TW = ADDRESS_WIDTH - 2 - WO - IX;

    // Memory read channel: MEM_READ_REQUEST and MEM_ADDRESS are raised together
    // and held unchanged until a cycle in which MEM_READ_VALID is high; that cycle
    // transfers MEM_READ_DATA for MEM_ADDRESS and retires the request. A
    // MEM_READ_VALID seen while no request is outstanding carries no data.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state;

    // Line storage: data words indexed by {line, word}, one tag and valid bit per line
    logic [DATA_WIDTH-1:0] data_array [LINE_COUNT*WORDS_PER_LINE];
    logic [TW-1:0]         tag_array  [LINE_COUNT];
    logic [LINE_COUNT-1:0] valid_bits;

    // Fields of the incoming PC
    logic [TW-1:0] pc_tag;
    logic [IX-1:0] pc_index;
    logic [WO-1:0] pc_word;

    // Fields of the PC that missed, held for the whole refill
    logic [TW-1:0] miss_tag;
    logic [IX-1:0] miss_index;
    logic [WO-1:0] miss_word;

    logic [WO-1:0] word_cnt;
    logic          flush_pending;
    logic          lookup_hit;
    logic          refill_beat;
    logic          last_beat;
    logic          unused_pc_bits;

    assign pc_word  = PC[2 +: WO];
    assign pc_index = PC[2 + WO +: IX];
    assign pc_tag   = PC[ADDRESS_WIDTH-1 -: TW];

    // Byte-offset bits never matter for word fetches
    assign unused_pc_bits = ^PC[1:0];

    // A flush on the lookup edge makes every line look invalid
    assign lookup_hit = valid_bits[pc_index] && (tag_array[pc_index] == pc_tag) && !FLUSH;

    // A beat only counts while a request is actually outstanding
    assign refill_beat = (state == REFILL) && MEM_READ_REQUEST && MEM_READ_VALID;
    assign last_beat   = (word_cnt == WO'(WORDS_PER_LINE - 1));

    // Line array writes: refill words as they arrive, tag once the line is complete
    always_ff @(posedge CLK) begin
        if (!RST && refill_beat) begin
            data_array[{miss_index, word_cnt}] <= MEM_READ_DATA;
        end
        if (!RST && state == UPDATE) begin
            tag_array[miss_index] <= miss_tag;
        end
    end

    // Control FSM, valid bits and all registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state                   <= IDLE;
            valid_bits              <= '0;
            word_cnt                <= '0;
            flush_pending           <= LOW;
            miss_tag                <= '0;
            miss_index              <= '0;
            miss_word               <= '0;
            INSTRUCTION             <= '0;
            INSTRUCTION_CACHE_READY <= LOW;
            MEM_READ_REQUEST        <= LOW;
            MEM_ADDRESS             <= '0;
        end else begin
            if (FLUSH) begin
                valid_bits <= '0;
            end
            case (state)
                IDLE: begin
                    if (!INSTRUCTION_CACHE_STALL) begin
                        if (PC_VALID && lookup_hit) begin
                            INSTRUCTION             <= data_array[{pc_index, pc_word}];
                            INSTRUCTION_CACHE_READY <= HIGH;
                        end else if (PC_VALID) begin
                            INSTRUCTION_CACHE_READY <= LOW;
                            miss_tag                <= pc_tag;
                            miss_index              <= pc_index;
                            miss_word               <= pc_word;
                            word_cnt                <= '0;
                            flush_pending           <= LOW;
                            state                   <= REFILL;
                        end else begin
                            INSTRUCTION_CACHE_READY <= LOW;
                        end
                    end
                end
                REFILL: begin
                    if (FLUSH) begin
                        flush_pending <= HIGH;
                    end
                    if (!MEM_READ_REQUEST) begin
                        // First cycle of the refill: issue the line-aligned request
                        MEM_READ_REQUEST <= HIGH;
                        MEM_ADDRESS      <= {miss_tag, miss_index, word_cnt, 2'b00};
                    end else if (MEM_READ_VALID) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_beat) begin
                            MEM_READ_REQUEST <= LOW;
                            state            <= UPDATE;
                        end else begin
                            MEM_ADDRESS <= {miss_tag, miss_index, word_cnt + 1'b1, 2'b00};
                        end
                    end
                end
                UPDATE: begin
                    // A flush seen at any point of this refill leaves the line invalid
                    valid_bits[miss_index] <= !(flush_pending || FLUSH);
                    if (FLUSH) begin
                        flush_pending <= HIGH;
                    end
                    if (!INSTRUCTION_CACHE_STALL) begin
                        INSTRUCTION             <= data_array[{miss_index, miss_word}];
                        INSTRUCTION_CACHE_READY <= HIGH;
                        state                   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
